// File: rtl/dart_score_ctrl.sv
// dart_score_ctrl: two-player countdown dart game (impact -> ring score -> points, turns, winner).
// Define DART_BUST_EN to restore turn-start points on overshoot; otherwise overshoot saturates to a win.
module dart_score_ctrl #(
    parameter int START_PT       = 301,
    parameter int DARTS_PER_TURN = 3,
    parameter int CX             = 128,
    parameter int CY             = 128
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dart_come_i,
    input  logic [7:0] dart_position_x_i,
    input  logic [7:0] dart_position_y_i,
    output logic       game_set_o,
    output logic       player_1_done_o,
    output logic       player_2_done_o,
    output logic       player_1_win_o,
    output logic       player_2_win_o,
    output logic [8:0] player_1_pt_o,
    output logic [8:0] player_2_pt_o
);
    localparam logic [2:0] S_WAIT   = 3'd0;
    localparam logic [2:0] S_CALC   = 3'd1;
    localparam logic [2:0] S_SCORE  = 3'd2;
    localparam logic [2:0] S_UPDATE = 3'd3;
    localparam logic [2:0] S_OVER   = 3'd4;
    localparam logic [8:0] PT0 = 9'(START_PT);
    localparam logic [2:0] DPT = 3'(DARTS_PER_TURN);
    localparam logic [8:0] CX9 = 9'(CX);
    localparam logic [8:0] CY9 = 9'(CY);

    logic [2:0]  state_q, state_d;
    logic        come_q, come_d;
    logic [7:0]  x_q, x_d, y_q, y_d;
    logic [16:0] d2_q, d2_d;
    logic [5:0]  score_q, score_d;
    logic [8:0]  p1_q, p1_d, p2_q, p2_d, snap_q, snap_d;
    logic        turn_q, turn_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        done1_q, done1_d, done2_q, done2_d;
    logic        win1_q, win1_d, win2_q, win2_d, set_q, set_d;
    logic signed [8:0]  dx9, dy9;
    logic signed [16:0] dx, dy, sq;
    logic signed [9:0]  rem;
    logic [8:0]  act_pt, new_pt;
    logic        win, bust, turn_end;

    always_comb begin
        dx9 = {1'b0, x_q} - CX9;
        dy9 = {1'b0, y_q} - CY9;
        dx = 17'(dx9);
        dy = 17'(dy9);
        sq = dx * dx + dy * dy;
        act_pt = turn_q ? p2_q : p1_q;
        rem = 10'(act_pt) - 10'(score_q);
`ifdef DART_BUST_EN
        win  = rem == 10'sd0;
        bust = rem < 10'sd0;
`else
        win  = rem <= 10'sd0;
        bust = 1'b0;
`endif
        turn_end = bust | (cnt_q + 3'd1 == DPT);
        new_pt = win ? 9'd0 : bust ? snap_q : rem[8:0];
        state_d = state_q;
        come_d = dart_come_i;
        x_d = x_q;
        y_d = y_q;
        d2_d = d2_q;
        score_d = score_q;
        p1_d = p1_q;
        p2_d = p2_q;
        snap_d = snap_q;
        turn_d = turn_q;
        cnt_d = cnt_q;
        done1_d = 1'b0;
        done2_d = 1'b0;
        win1_d = win1_q;
        win2_d = win2_q;
        set_d = set_q;
        case (state_q)
            S_WAIT: if (dart_come_i & ~come_q) begin
                x_d = dart_position_x_i;
                y_d = dart_position_y_i;
                state_d = S_CALC;
            end
            S_CALC: begin
                d2_d = sq;
                state_d = S_SCORE;
            end
            S_SCORE: begin
                score_d = d2_q <= 17'd64    ? 6'd50 :
                          d2_q <= 17'd256   ? 6'd25 :
                          d2_q <= 17'd1600  ? 6'd20 :
                          d2_q <= 17'd3600  ? 6'd15 :
                          d2_q <= 17'd6400  ? 6'd10 :
                          d2_q <= 17'd10000 ? 6'd5  : 6'd0;
                state_d = S_UPDATE;
            end
            S_UPDATE: begin
                p1_d = turn_q ? p1_q : new_pt;
                p2_d = turn_q ? new_pt : p2_q;
                if (win) begin
                    win1_d = ~turn_q;
                    win2_d = turn_q;
                    set_d = 1'b1;
                    done1_d = ~turn_q;
                    done2_d = turn_q;
                    state_d = S_OVER;
                end else begin
                    // the incoming player's points become the new turn-start snapshot
                    cnt_d = turn_end ? 3'd0 : cnt_q + 3'd1;
                    done1_d = turn_end & ~turn_q;
                    done2_d = turn_end & turn_q;
                    turn_d = turn_end ? ~turn_q : turn_q;
                    snap_d = turn_end ? (turn_q ? p1_q : p2_q) : snap_q;
                    state_d = S_WAIT;
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_WAIT;
            come_q <= 1'b0;
            x_q <= 8'd0;
            y_q <= 8'd0;
            d2_q <= 17'd0;
            score_q <= 6'd0;
            p1_q <= PT0;
            p2_q <= PT0;
            snap_q <= PT0;
            turn_q <= 1'b0;
            cnt_q <= 3'd0;
            done1_q <= 1'b0;
            done2_q <= 1'b0;
            win1_q <= 1'b0;
            win2_q <= 1'b0;
            set_q <= 1'b0;
        end else begin
            state_q <= state_d;
            come_q <= come_d;
            x_q <= x_d;
            y_q <= y_d;
            d2_q <= d2_d;
            score_q <= score_d;
            p1_q <= p1_d;
            p2_q <= p2_d;
            snap_q <= snap_d;
            turn_q <= turn_d;
            cnt_q <= cnt_d;
            done1_q <= done1_d;
            done2_q <= done2_d;
            win1_q <= win1_d;
            win2_q <= win2_d;
            set_q <= set_d;
        end
    end

    assign game_set_o = set_q;
    assign player_1_done_o = done1_q;
    assign player_2_done_o = done2_q;
    assign player_1_win_o = win1_q;
    assign player_2_win_o = win2_q;
    assign player_1_pt_o = p1_q;
    assign player_2_pt_o = p2_q;
endmodule

// File: tb/tb_dart_score_ctrl.sv
// tb_dart_score_ctrl: scoreboard bench for dart_score_ctrl; a game model predicts every visible output change.
module tb_dart_score_ctrl;
    localparam int ST = 100;
    localparam int DPT = 3;
    localparam int CX = 128;
    localparam int CY = 128;
`ifdef DART_BUST_EN
    localparam bit BUST = 1'b1;
`else
    localparam bit BUST = 1'b0;
`endif
    localparam logic [22:0] RST_V = {9'(ST), 9'(ST), 5'b0};

    logic clk = 1'b0, reset = 1'b0, come = 1'b0;
    logic [7:0] px = 8'd0, py = 8'd0;
    logic gs, d1, d2, w1, w2;
    logic [8:0] p1, p2;

    dart_score_ctrl #(.START_PT(ST), .DARTS_PER_TURN(DPT), .CX(CX), .CY(CY)) dut (
        .clk(clk), .reset(reset), .dart_come_i(come),
        .dart_position_x_i(px), .dart_position_y_i(py),
        .game_set_o(gs), .player_1_done_o(d1), .player_2_done_o(d2),
        .player_1_win_o(w1), .player_2_win_o(w2),
        .player_1_pt_o(p1), .player_2_pt_o(p2)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        logic [22:0] v;
    } exp_t;
    exp_t q[$];
    exp_t m;
    int total = 0, bad = 0;
    int pts[2];
    int act, nd, snap, last_e;
    bit over;
    bit w[2];
    logic [22:0] cur, prev;
    assign cur = {p1, p2, d1, d2, w1, w2, gs};

    function automatic int ring(int x, int y);
        int d = (x - CX) * (x - CX) + (y - CY) * (y - CY);
        int lim[6] = '{64, 256, 1600, 3600, 6400, 10000};
        int sc[6] = '{50, 25, 20, 15, 10, 5};
        for (int i = 0; i < 6; i++) if (d <= lim[i]) return sc[i];
        return 0;
    endfunction

    task automatic model_init();
        pts = '{ST, ST};
        act = 0;
        nd = 0;
        snap = ST;
        over = 0;
        w = '{0, 0};
        last_e = -100;
    endtask

    task automatic model_dart(int x, int y, int e);
        int s, rem, who;
        bit done;
        exp_t ex;
        if (over || e - last_e < 4) return;
        last_e = e;
        s = ring(x, y);
        who = act;
        rem = pts[act] - s;
        done = 0;
        if (rem == 0 || (rem < 0 && !BUST)) begin
            pts[act] = 0;
            w[act] = 1;
            over = 1;
            done = 1;
        end else if (rem < 0) begin
            pts[act] = snap;
            done = 1;
            act = 1 - act;
            nd = 0;
            snap = pts[act];
        end else begin
            pts[act] = rem;
            nd++;
            if (nd == DPT) begin
                done = 1;
                act = 1 - act;
                nd = 0;
                snap = pts[act];
            end
        end
        if (done || s != 0) begin
            ex.cyc = e + 3;
            ex.v = {9'(pts[0]), 9'(pts[1]), done && who == 0, done && who == 1, w[0], w[1], over};
            q.push_back(ex);
        end
    endtask

    task automatic chk(string n, logic [22:0] a, logic [22:0] x);
        total++;
        if (a !== x) begin
            bad++;
            $display("FAIL %s got p1=%0d p2=%0d flags=%b want p1=%0d p2=%0d flags=%b",
                     n, a[22:14], a[13:5], a[4:0], x[22:14], x[13:5], x[4:0]);
        end
    endtask

    task automatic fire(int x, int y, int gap);
        @(posedge clk); #1;
        px = 8'(x);
        py = 8'(y);
        come = 1'b1;
        @(posedge clk); #1;
        come = 1'b0;
        model_dart(x, y, cyc);
        repeat (gap - 2) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset(bit held, int x, int y);
        @(posedge clk); #1;
        reset = 1'b1;
        come = held;
        px = 8'(x);
        py = 8'(y);
        #1;
        chk("reset_async", cur, RST_V);
        q.delete();
        model_init();
        repeat (2) begin @(posedge clk); #1; end
        chk("reset_hold", cur, RST_V);
        reset = 1'b0;
        if (held) begin
            @(posedge clk); #1;
            model_dart(x, y, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset) prev = cur;
        else begin
            if (cur[4] || cur[3] || {cur[22:5], cur[2:0]} != {prev[22:5], prev[2:0]}) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change cyc=%0d got p1=%0d p2=%0d flags=%b",
                             cyc, cur[22:14], cur[13:5], cur[4:0]);
                end else begin
                    m = q.pop_front();
                    if (m.v !== cur || m.cyc != cyc) begin
                        bad++;
                        $display("FAIL scoreboard cyc=%0d got p1=%0d p2=%0d flags=%b want cyc=%0d p1=%0d p2=%0d flags=%b",
                                 cyc, cur[22:14], cur[13:5], cur[4:0], m.cyc, m.v[22:14], m.v[13:5], m.v[4:0]);
                    end
                end
            end
            prev = cur;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        model_init();
        do_reset(1'b1, 128, 128);
        repeat (7) begin @(posedge clk); #1; end
        come = 1'b0;
        fire(140, 128, 2);
        fire(128, 128, 3);
        fire(15, 29, 6);
        fire(128, 128, 6);
        fire(128, 158, 6);
        fire(0, 0, 6);
        fire(128, 128, 6);
        fire(128, 128, 6);
        fire(128, 158, 6);
        repeat (6) begin @(posedge clk); #1; end
        do_reset(1'b0, 0, 0);
        fire(128, 128, 6);
        fire(128, 128, 6);
        fire(128, 128, 6);
        fire(140, 128, 6);
        repeat (6) begin @(posedge clk); #1; end
        do_reset(1'b0, 0, 0);
        fire(140, 128, 6);
        fire(0, 0, 6);
        fire(0, 0, 6);
        fire(128, 128, 2);
        do_reset(1'b0, 0, 0);
        fire(128, 128, 6);
        repeat (6) begin @(posedge clk); #1; end
        for (int g = 0; g < 4; g++) begin
            do_reset(1'b0, 0, 0);
            repeat (30) fire(int'($urandom_range(20, 236)), int'($urandom_range(20, 236)),
                             int'($urandom_range(3, 7)));
            repeat (6) begin @(posedge clk); #1; end
        end
        for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL pending_expectations got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dart_score_ctrl.md
# dart_score_ctrl

Dart game controller that consumes the dart stream (`dart_come`, x/y impact position) from the stimulus/sensor stage. It converts each impact into a ring score, runs a two-player countdown game, and reports turn completion, points, winner and game-over to the checker stage. Each player starts from `START_PT`, alternates turns of `DARTS_PER_TURN` darts, and wins on reaching exactly 0.

## Interface

Parameters:
- `START_PT`, default 301: initial points per player (1..511).
- `DARTS_PER_TURN`, default 3: darts per turn (1..7).
- `CX`, default 128: board centre x.
- `CY`, default 128: board centre y.

Ports:
- `clk`, input, 1: system clock, rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `dart_come_i`, input, 1: dart-present level. A rising edge signals a new dart.
- `dart_position_x_i`, input, 8: impact x, unsigned.
- `dart_position_y_i`, input, 8: impact y, unsigned.
- `game_set_o`, output, 1: game over, held high.
- `player_1_done_o`, output, 1: one-cycle pulse at the end of P1's turn.
- `player_2_done_o`, output, 1: one-cycle pulse at the end of P2's turn.
- `player_1_win_o`, output, 1: P1 won, held high.
- `player_2_win_o`, output, 1: P2 won, held high.
- `player_1_pt_o`, output, 9: P1 remaining points.
- `player_2_pt_o`, output, 9: P2 remaining points.

## Operation

- **States:** WAIT, CALC, SCORE, UPDATE, OVER.
- **Dart acceptance:**
  - `dart_come_d` is a registered copy of `dart_come_i`.
  - A dart is accepted when `dart_come_i & ~dart_come_d` is true in WAIT. x/y are latched on that edge.
  - An edge arriving in any other state is dropped, not queued.
- **Distance (CALC):**
  - dx = x − CX and dy = y − CY, each 9-bit signed.
  - d2 = dx² + dy², 17-bit unsigned, registered.
- **Ring score (SCORE), 6-bit, first match wins:**
  - d2 ≤ 64 → 50
  - ≤ 256 → 25
  - ≤ 1600 → 20
  - ≤ 3600 → 15
  - ≤ 6400 → 10
  - ≤ 10000 → 5
  - otherwise 0 (miss)
- **Points update (UPDATE), on the active player:**
  - rem = pt − score, computed 10-bit signed.
  - rem > 0: pt ← rem; dart count increments.
  - rem == 0: pt ← 0. Win flag, `game_set_o` and the done pulse are set. Next state is OVER.
  - rem < 0: handled per `## Configuration`.
  - Dart count reaching `DARTS_PER_TURN`: done pulse; active player toggles; count ← 0.
- **Turn state:**
  - A turn-start snapshot of the active player's points is captured whenever a turn begins.
  - P1 starts after reset.
- **OVER:** absorbing. Darts are ignored and all outputs hold until reset.

## Timing

- **Reset values:**
  - `player_1_pt_o` = `player_2_pt_o` = `START_PT`.
  - All flags and pulses 0.
  - `dart_come_d` = 0, so `dart_come_i` already high at reset release counts as one dart.
  - State WAIT, active player P1, dart count 0.
- **Latency** (E0 = the clock edge that samples the accepting rising edge):
  - d2 registered at E1.
  - Score registered at E2.
  - pt, done and win registered at E3.
  - State is WAIT after E3. The earliest next accepted edge is sampled at E4.
- **Pulse width:** done pulses are high for exactly the one cycle following E3.
- **Win and turn end coincide:** only one done pulse is issued, for the winner.
- **Reset mid-operation:** outputs return to reset values immediately (asynchronous). The in-flight dart is discarded.
- **Minimum dart spacing:** 4 cycles. Tighter spacing drops darts.

## Configuration

- Macro `DART_BUST_EN`.
- **Defined:** rem < 0 is a bust.
  - Active player's pt is restored to the turn-start snapshot.
  - Done pulse issued; turn passes immediately; dart count ← 0.
- **Undefined:** rem < 0 saturates.
  - pt ← 0 and is treated exactly as the rem == 0 win case.

## Test plan

1. **Single bull:** reset, then rising edge with (128,128). Required: d2 = 0, score 50, `player_1_pt_o` = 251 at E3, no done pulse, `player_2_pt_o` = 301.
2. **Full P1 turn:** darts at (128,128), (140,128) [d2 = 144 → 25], (15,29) [d2 = 22570 → miss]. Required: `player_1_pt_o` = 226; `player_1_done_o` pulses once at E3 of dart 3; next dart (128,128) gives `player_2_pt_o` = 251.
3. **Held and early edges:** hold `dart_come_i` high from reset. Required: exactly one dart scored. Toggling low/high again 2 cycles after acceptance is dropped (pt unchanged); the same toggle 5 cycles after acceptance is scored.
4. **Overshoot, `START_PT` = 60:** P1 darts (128,128) → 10 remaining, then (128,158) [d2 = 900 → 20].
   - With `DART_BUST_EN`: pt restored to 60, `player_1_done_o` pulses, next dart goes to P2.
   - Without it: pt = 0, `player_1_win_o` = 1, `game_set_o` = 1.
5. **Exact win, `START_PT` = 100:** P1 two bulls. Required at E3 of dart 2: `player_1_pt_o` = 0, `player_1_win_o` = 1, `game_set_o` = 1, one `player_1_done_o` pulse. Subsequent darts leave all outputs unchanged.
6. **Reset mid-dart:** assert `reset` during SCORE of a P2 dart. Required: all outputs at reset values within the same cycle. After release, the next dart is credited to P1.
